vending_machine_gen: RTL and testbench

Parametrised successor to the two-product vending controller.
- Serves NUM_PROD products with per-product prices and per-product stock counters.
- Accepts 1/2/5 coins and vends one product per selection.
- Returns change or a refund one coin per cycle, using a greedy 5/2/1 split.
- Sits between the coin-acceptor/keypad front end and the dispenser actuators; all outputs are registered.

---
 rtl/vm_pkg.sv | 19 +
 rtl/vm_change_sel.sv | 34 +++
 rtl/vending_machine_gen.sv | 197 +++++++++++++++++++
 tb/tb_vending_machine_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the parametrised vending controller.
//   - COIN_*    : face values of the accepted coins.
//   - vm_state_t: controller state encoding (IDLE, VEND, CHANGE).
// ---------------------------------------------------------------------------
package vm_pkg;

    localparam int unsigned COIN_N = 1;
    localparam int unsigned COIN_D = 2;
    localparam int unsigned COIN_Q = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } vm_state_t;

endpackage

// File: rtl/vm_change_sel.sv
// ---------------------------------------------------------------------------
// vm_change_sel
// Combinational greedy coin pick for change/refund: largest coin that fits.
//   i_credit : credit still owed to the customer
//   o_coin   : one-hot {C5, C2, C1}; all zero when nothing is owed
//   o_dec    : value of the picked coin, to subtract from the credit
// ---------------------------------------------------------------------------
module vm_change_sel
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] i_credit,
    output logic [2:0]          o_coin,
    output logic [CREDIT_W-1:0] o_dec
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_coin = 3'b000;
        o_dec  = '0;
        if (i_credit >= CREDIT_W'(COIN_Q)) begin
            o_coin = 3'b100;
            o_dec  = CREDIT_W'(COIN_Q);
        end else if (i_credit >= CREDIT_W'(COIN_D)) begin
            o_coin = 3'b010;
            o_dec  = CREDIT_W'(COIN_D);
        end else if (i_credit != '0) begin
            o_coin = 3'b001;
            o_dec  = CREDIT_W'(COIN_N);
        end
    end

endmodule

// File: rtl/vending_machine_gen.sv
// ---------------------------------------------------------------------------
// vending_machine_gen
// Parametrised vending controller: NUM_PROD products with per-product price
// and stock, 1/2/5 coin acceptance, greedy change/refund one coin per cycle.
// All outputs are registered.
//   clk, Reset      : clock, synchronous active-high reset
//   N, D, Q         : 1/2/5-unit coin pulses
//   CR              : coin-return request (beats sel)
//   sel             : product select, lowest set bit wins
//   vend_out        : one-cycle one-hot vend pulse
//   C1, C2, C5      : dispense one coin of that value this cycle
//   coin_reject     : this cycle's coins were bounced
//   deny            : selection refused (short credit or sold out)
//   sold_out        : level, product stock is zero
//   credit          : current credit
//   busy            : high in VEND and CHANGE
// ---------------------------------------------------------------------------
module vending_machine_gen
    import vm_pkg::*;
#(
    parameter int                            NUM_PROD   = 4,
    parameter int                            PRICE_W    = 5,
    parameter logic [NUM_PROD*PRICE_W-1:0]   PRICES     = {5'd4, 5'd10, 5'd13, 5'd8},
    parameter int                            CREDIT_W   = 6,
    parameter int                            MAX_CREDIT = 31,
    parameter int                            STOCK_W    = 4,
    parameter int                            STOCK_INIT = 9
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                CR,
    input  logic [NUM_PROD-1:0] sel,
    output logic [NUM_PROD-1:0] vend_out,
    output logic                C1,
    output logic                C2,
    output logic                C5,
    output logic                coin_reject,
    output logic                deny,
    output logic [NUM_PROD-1:0] sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    // Price and credit are compared at a width that holds either without loss.
    localparam int CMP_W = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;

    vm_state_t           r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [STOCK_W-1:0]  r_stock [NUM_PROD];
    logic [NUM_PROD-1:0] r_vend;
    logic [NUM_PROD-1:0] r_sold;
    logic [2:0]          r_coin;          // {C5, C2, C1}
    logic                r_rej;
    logic                r_deny;
    logic                r_busy;

    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_total;
    logic                w_coin_any;
    logic                w_over;
    logic [CREDIT_W-1:0] w_new_credit;
    logic                w_sel_any;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [NUM_PROD-1:0] w_sel_onehot;
    logic [PRICE_W-1:0]  w_price;
    logic                w_short;
    logic                w_stock_zero;
    logic [CREDIT_W-1:0] w_after_vend;
    logic [CREDIT_W-1:0] w_pay;
    logic [2:0]          w_coin;
    logic [CREDIT_W-1:0] w_dec;

    // Coin arithmetic: the whole cycle's coins are accepted or bounced together.
    always_comb begin
        w_sum = '0;
        if (N) w_sum = w_sum + (CREDIT_W+1)'(COIN_N);
        if (D) w_sum = w_sum + (CREDIT_W+1)'(COIN_D);
        if (Q) w_sum = w_sum + (CREDIT_W+1)'(COIN_Q);
    end

    assign w_coin_any   = N | D | Q;
    assign w_total      = {1'b0, r_credit} + w_sum;
    assign w_over       = (w_total > (CREDIT_W+1)'(MAX_CREDIT));
    assign w_new_credit = w_over ? r_credit : w_total[CREDIT_W-1:0];

    // Lowest set select bit wins: scan downwards so the lowest index lands last.
    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_PROD - 1; i >= 0; i--) begin
            if (sel[i]) w_sel_idx = IDX_W'(i);
        end
    end

    assign w_sel_any    = |sel;
    assign w_sel_onehot = sel & ~(sel - NUM_PROD'(1));
    assign w_price      = PRICES[w_sel_idx*PRICE_W +: PRICE_W];
    // Affordability is judged on the credit held before this cycle's coins.
    assign w_short      = (CMP_W'(r_credit) < CMP_W'(w_price));
    assign w_stock_zero = (r_stock[w_sel_idx] == '0);
    // Only used when not short, so price <= credit and the result is non-negative.
    assign w_after_vend = w_new_credit - CREDIT_W'(w_price);

    // A refund pays out of the just-updated credit; VEND/CHANGE pay out of the register.
    assign w_pay = (r_state == ST_IDLE) ? w_new_credit : r_credit;

    vm_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_change_sel (
        .i_credit (w_pay),
        .o_coin   (w_coin),
        .o_dec    (w_dec)
    );

    // Entering or staying in CHANGE registers the coin together with the
    // post-decrement credit, so each CHANGE cycle shows exactly one coin.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_vend   <= '0;
            r_coin   <= '0;
            r_rej    <= 1'b0;
            r_deny   <= 1'b0;
            r_busy   <= 1'b0;
            r_sold   <= {NUM_PROD{(STOCK_INIT == 0)}};
            // NOTE: the stock array is a handful of flops, not a RAM, so resetting every entry is cheap and required.
            for (int i = 0; i < NUM_PROD; i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override these pulse defaults.
            r_vend <= '0;
            r_coin <= '0;
            r_rej  <= 1'b0;
            r_deny <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_rej <= w_over;
                    if (CR) begin
                        if (w_new_credit != '0) begin
                            r_state  <= ST_CHANGE;
                            r_busy   <= 1'b1;
                            r_coin   <= w_coin;
                            r_credit <= w_new_credit - w_dec;
                        end else begin
                            r_credit <= w_new_credit;
                        end
                    end else if (w_sel_any) begin
                        if (w_stock_zero || w_short) begin
                            r_deny   <= 1'b1;
                            r_credit <= w_new_credit;
                        end else begin
                            r_state              <= ST_VEND;
                            r_busy               <= 1'b1;
                            r_vend               <= w_sel_onehot;
                            r_credit             <= w_after_vend;
                            r_stock[w_sel_idx]   <= r_stock[w_sel_idx] - STOCK_W'(1);
                            r_sold[w_sel_idx]    <= (r_stock[w_sel_idx] == STOCK_W'(1));
                        end
                    end else begin
                        r_credit <= w_new_credit;
                    end
                end
                ST_VEND, ST_CHANGE: begin
                    r_rej <= w_coin_any;
                    if (r_credit != '0) begin
                        r_state  <= ST_CHANGE;
                        r_coin   <= w_coin;
                        r_credit <= r_credit - w_dec;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign vend_out    = r_vend;
    assign C5          = r_coin[2];
    assign C2          = r_coin[1];
    assign C1          = r_coin[0];
    assign coin_reject = r_rej;
    assign deny        = r_deny;
    assign sold_out    = r_sold;
    assign credit      = r_credit;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vending_machine_gen.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_gen
// Self-checking bench for vending_machine_gen. Two instances share stimulus:
// u_dut uses default parameters, u_dut1 has STOCK_INIT=1 for sold-out cases.
// Each scenario is a table of per-cycle inputs with the outputs expected after
// that clock edge; expectations go through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_vending_machine_gen;

    localparam int NP = 4;
    localparam int CW = 6;

    typedef struct packed {
        logic          rst;
        logic          n;
        logic          d;
        logic          q;
        logic          cr;
        logic [NP-1:0] sel;
    } stim_t;

    typedef struct packed {
        logic [NP-1:0] vend;
        logic [2:0]    coin;   // {C5, C2, C1}
        logic          rej;
        logic          deny;
        logic [NP-1:0] sold;
        logic [CW-1:0] credit;
        logic          busy;
    } obs_t;

    typedef struct {
        bit    which;          // 0: u_dut, 1: u_dut1
        stim_t s;
        obs_t  e;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset, N, D, Q, CR;
    logic [NP-1:0] sel;

    logic [NP-1:0] vend_a, sold_a, vend_b, sold_b;
    logic          c1_a, c2_a, c5_a, rej_a, deny_a, busy_a;
    logic          c1_b, c2_b, c5_b, rej_b, deny_b, busy_b;
    logic [CW-1:0] credit_a, credit_b;

    int   n_pass  = 0;
    int   n_total = 0;
    obs_t sb [$];

    vending_machine_gen u_dut (
        .clk (clk), .Reset (Reset), .N (N), .D (D), .Q (Q), .CR (CR), .sel (sel),
        .vend_out (vend_a), .C1 (c1_a), .C2 (c2_a), .C5 (c5_a),
        .coin_reject (rej_a), .deny (deny_a), .sold_out (sold_a),
        .credit (credit_a), .busy (busy_a)
    );

    vending_machine_gen #(.STOCK_INIT (1)) u_dut1 (
        .clk (clk), .Reset (Reset), .N (N), .D (D), .Q (Q), .CR (CR), .sel (sel),
        .vend_out (vend_b), .C1 (c1_b), .C2 (c2_b), .C5 (c5_b),
        .coin_reject (rej_b), .deny (deny_b), .sold_out (sold_b),
        .credit (credit_b), .busy (busy_b)
    );

    function automatic step_t mk(input bit w, input logic rst, input logic n, input logic d,
                                 input logic q, input logic cr, input logic [NP-1:0] s,
                                 input logic [NP-1:0] vend, input logic [2:0] coin,
                                 input logic rej, input logic dn, input logic [NP-1:0] sold,
                                 input int cred, input logic bsy);
        step_t t;
        t.which = w;
        t.s     = '{rst: rst, n: n, d: d, q: q, cr: cr, sel: s};
        t.e     = '{vend: vend, coin: coin, rej: rej, deny: dn, sold: sold,
                    credit: CW'(cred), busy: bsy};
        return t;
    endfunction

    function automatic obs_t observe(input bit which);
        obs_t o;
        if (which)
            o = '{vend: vend_b, coin: {c5_b, c2_b, c1_b}, rej: rej_b, deny: deny_b,
                  sold: sold_b, credit: credit_b, busy: busy_b};
        else
            o = '{vend: vend_a, coin: {c5_a, c2_a, c1_a}, rej: rej_a, deny: deny_a,
                  sold: sold_a, credit: credit_a, busy: busy_a};
        return o;
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("vend=%b coin(C5C2C1)=%b rej=%b deny=%b sold=%b credit=%0d busy=%b",
                         o.vend, o.coin, o.rej, o.deny, o.sold, o.credit, o.busy);
    endfunction

    // Drive one cycle of inputs and sample the outputs just after the edge.
    task automatic apply(input stim_t s);
        Reset = s.rst; N = s.n; D = s.d; Q = s.q; CR = s.cr; sel = s.sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(1, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL reset[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    task automatic test_exact_vend();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h1, 4'h1,3'b000,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL exact_vend[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    task automatic test_vend_change();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0,  8,0));
        st.push_back(mk(0, 0,0,0,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 13,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h1, 4'h1,3'b000,0,0,4'h0,  5,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b100,0,0,4'h0,  0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0,  0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL vend_change[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // Refund with sel also asserted (CR wins), CR at zero credit, CR with a coin.
    task automatic test_refund();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,1,4'h1, 4'h0,3'b100,0,0,4'h0, 3,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b010,0,0,4'h0, 1,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b001,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(0, 0,0,0,0,1,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(0, 0,1,0,0,1,4'h0, 4'h0,3'b001,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL refund[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // Credit ceiling, then a long greedy refund of 31 (six 5s and one 1).
    task automatic test_saturation();
        step_t st [$];
        obs_t  got, want;
        for (int i = 1; i <= 6; i++)
            st.push_back(mk(0, 0,0,0,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 5*i,0));
        st.push_back(mk(0, 0,0,1,0,0,4'h0, 4'h0,3'b000,1,0,4'h0, 30,0));
        st.push_back(mk(0, 0,1,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 31,0));
        st.push_back(mk(0, 0,1,0,0,0,4'h0, 4'h0,3'b000,1,0,4'h0, 31,0));
        st.push_back(mk(0, 0,0,0,0,1,4'h0, 4'h0,3'b100,0,0,4'h0, 26,1));
        for (int i = 1; i <= 5; i++)
            st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b100,0,0,4'h0, 26-5*i,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b001,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL saturation[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // Credit 3 plus a Q in the same cycle as sel: judged on 3, so denied, coin kept.
    task automatic test_price_sampling();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 3,0));
        st.push_back(mk(0, 0,0,0,1,0,4'h1, 4'h0,3'b000,0,1,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h1, 4'h1,3'b000,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL price_sampling[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // Lowest-set-bit selection across products with prices 8/13/10/4.
    task automatic test_select_priority();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'hC, 4'h0,3'b000,0,1,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'hA, 4'h0,3'b000,0,1,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h8, 4'h8,3'b000,0,0,4'h0, 4,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b010,0,0,4'h0, 2,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b010,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,0,4'hF, 4'h1,3'b000,0,0,4'h0, 0,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL select_priority[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // Coins and selections arriving while busy are bounced / ignored.
    task automatic test_back_to_back();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0,  8,0));
        st.push_back(mk(0, 0,0,0,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 13,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h1, 4'h1,3'b000,0,0,4'h0,  5,1));
        st.push_back(mk(0, 0,1,0,0,0,4'h1, 4'h0,3'b100,1,0,4'h0,  0,1));
        st.push_back(mk(0, 0,0,1,0,1,4'h0, 4'h0,3'b000,1,0,4'h0,  0,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0,  0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL back_to_back[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_change();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(0, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(0, 0,0,0,0,1,4'h0, 4'h0,3'b100,0,0,4'h0, 3,1));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b010,0,0,4'h0, 1,1));
        st.push_back(mk(0, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(0, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL reset_mid_change[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    // u_dut1 (one of each product): sell out, deny, reset restores stock, short credit.
    task automatic test_sold_out();
        step_t st [$];
        obs_t  got, want;
        st.push_back(mk(1, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(1, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h0, 8,0));
        st.push_back(mk(1, 0,0,0,0,0,4'h1, 4'h1,3'b000,0,0,4'h1, 0,1));
        st.push_back(mk(1, 0,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h1, 0,0));
        st.push_back(mk(1, 0,1,1,1,0,4'h0, 4'h0,3'b000,0,0,4'h1, 8,0));
        st.push_back(mk(1, 0,0,0,0,0,4'h1, 4'h0,3'b000,0,1,4'h1, 8,0));
        st.push_back(mk(1, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        st.push_back(mk(1, 0,1,1,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 3,0));
        st.push_back(mk(1, 0,0,0,0,0,4'h2, 4'h0,3'b000,0,1,4'h0, 3,0));
        st.push_back(mk(1, 1,0,0,0,0,4'h0, 4'h0,3'b000,0,0,4'h0, 0,0));
        foreach (st[k]) begin
            sb.push_back(st[k].e);
            apply(st[k].s);
            want = sb.pop_front();
            got  = observe(st[k].which);
            n_total++;
            if (got !== want) $display("FAIL sold_out[%0d]: got %s, want %s", k, show(got), show(want));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_refund();
        test_saturation();
        test_price_sampling();
        test_select_priority();
        test_back_to_back();
        test_reset_mid_change();
        test_sold_out();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
